// File: rtl/mem_hs_pkg.sv
// Shared types and constants for the handshaked data memory.
package mem_hs_pkg;

  // Access types; encodings 3, 6 and 7 are undefined and rejected at accept.
  typedef enum logic [2:0] {
    MEM_BYTE  = 3'd0,
    MEM_HALF  = 3'd1,
    MEM_WORD  = 3'd2,
    MEM_UBYTE = 3'd4,
    MEM_UHALF = 3'd5
  } mem_dt_e;

  typedef enum logic {
    ERR_NONE   = 1'b0,
    ERR_ACCESS = 1'b1
  } errno_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  localparam logic [3:0] MEM_LANES_B0 = 4'b0001;
  localparam logic [3:0] MEM_LANES_B1 = 4'b0010;
  localparam logic [3:0] MEM_LANES_B2 = 4'b0100;
  localparam logic [3:0] MEM_LANES_B3 = 4'b1000;
  localparam logic [3:0] MEM_LANES_H0 = 4'b0011;
  localparam logic [3:0] MEM_LANES_H1 = 4'b1100;
  localparam logic [3:0] MEM_LANES_W  = 4'b1111;

  // Expand a 4-bit lane mask into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mem_hs_lane_ctl.sv
// Byte-lane decoder: {addr[1:0], dt} -> lane enables, sign-extend flag, access error.
module mem_lane_ctl
  import mem_hs_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  mem_dt_e    dt,
  output logic [3:0] be,
  output logic       se,
  output logic       misalign_err
);

  // Lane decode; undefined access types report an error with no lanes enabled.
  always_comb begin
    be           = '0;
    se           = 1'b0;
    misalign_err = 1'b0;
    case (dt)
      MEM_BYTE, MEM_UBYTE: begin
        be = MEM_LANES_B0 << addr_lo;
        se = (dt == MEM_BYTE);
      end
      MEM_HALF, MEM_UHALF: begin
        be           = addr_lo[1] ? MEM_LANES_H1 : MEM_LANES_H0;
        se           = (dt == MEM_HALF);
        misalign_err = addr_lo[0];
      end
      MEM_WORD: begin
        be           = MEM_LANES_W;
        misalign_err = |addr_lo;
      end
      default: misalign_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_hs.sv
// Handshaked byte-enable data memory with synchronous (block-RAM style) read
// and a one-slot response buffer sustaining one access per cycle.
module mem_hs
  import mem_hs_pkg::*;
#(
  parameter int N = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  input  logic        req_we,
  input  mem_dt_e     req_dt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output errno_e      rsp_err
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [31:0] mem_q [N];
  logic [31:0] rd_word_q;

  rsp_state_e  state_q, state_d;
  errno_e      err_q, err_d;
  logic        load_q, load_d;
  logic [3:0]  be_q, be_d;
  logic        se_q, se_d;
  logic [1:0]  off_q, off_d;

  logic [3:0]    req_be;
  logic          req_se;
  logic          req_misalign;
  logic          range_err;
  logic          acc_err;
  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic [31:0]   wr_data;
  logic [AW-1:0] mem_idx;
  logic [31:0]   ld_shifted;
  logic [31:0]   ld_ext;

  mem_lane_ctl u_lane_ctl (
    .addr_lo      (req_addr[1:0]),
    .dt           (req_dt),
    .be           (req_be),
    .se           (req_se),
    .misalign_err (req_misalign)
  );

  // Request-side handshake, error classification and array port controls.
  always_comb begin
    rsp_valid = (state_q == RSP_FULL);
    req_ready = ~rst & (~rsp_valid | rsp_ready);
    accept    = req_valid & req_ready;
    range_err = (req_addr[31:2] >= 30'(N));
    acc_err   = range_err | req_misalign;
    wr_en     = accept & req_we & ~acc_err;
    rd_en     = accept & ~req_we & ~acc_err;
    mem_idx   = req_addr[AW+1:2];
    case (req_dt)
      MEM_BYTE, MEM_UBYTE: wr_data = {4{req_wd[7:0]}};
      MEM_HALF, MEM_UHALF: wr_data = {2{req_wd[15:0]}};
      default:             wr_data = req_wd;
    endcase
  end

  // Array write and registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_be[i]) mem_q[mem_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_word_q <= mem_q[mem_idx];
  end

  // Response slot next state: fill on accept, drain when consumed.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    load_d  = load_q;
    be_d    = be_q;
    se_d    = se_q;
    off_d   = off_q;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL:  if (!accept && rsp_ready) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
    if (accept) begin
      err_d  = acc_err ? ERR_ACCESS : ERR_NONE;
      load_d = ~req_we;
      be_d   = req_be;
      se_d   = req_se;
      off_d  = req_addr[1:0];
    end
  end

  // Response slot registers; a response pending at reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RSP_EMPTY;
      err_q   <= ERR_NONE;
      load_q  <= 1'b0;
      be_q    <= '0;
      se_q    <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      load_q  <= load_d;
      be_q    <= be_d;
      se_q    <= se_d;
      off_q   <= off_d;
    end
  end

  // Lane extract and extend from the registered word; width follows the lane mask.
  always_comb begin
    ld_shifted = (rd_word_q & lane_mask(be_q)) >> {off_q, 3'b000};
    ld_ext     = ld_shifted;
    if (se_q) begin
      if (be_q == MEM_LANES_H0 || be_q == MEM_LANES_H1)
        ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      else
        ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
    end
    rsp_rd  = (load_q && err_q == ERR_NONE) ? ld_ext : '0;
    rsp_err = err_q;
  end

endmodule

// File: tb/tb_mem_hs.sv
// Directed self-checking bench for mem_hs.
module tb_mem_hs;
  import mem_hs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wd;
  logic        req_we;
  mem_dt_e     req_dt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  errno_e      rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_hs #(.N(64)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wd    (req_wd),
    .req_we    (req_we),
    .req_dt    (req_dt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rd    (rsp_rd),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    mem_dt_e     dt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input mem_dt_e dt, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.dt = dt; v.addr = addr; v.wd = wd; v.rd = rd; v.err = err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input mem_dt_e dt, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_dt    = dt;
    req_addr  = addr;
    req_wd    = wd;
  endtask

  // One request, response checked the cycle after accept, then drained.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vq[idx];
    @(negedge clk);
    rsp_ready = 1'b1;
    drive(v.we, v.dt, v.addr, v.wd);
    chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d rsp_rd", idx), rsp_rd, v.rd);
    chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.err));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d drained", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_dt    = MEM_WORD;
    req_addr  = '0;
    req_wd    = '0;
    rsp_ready = 1'b1;

    add(1'b1, MEM_WORD,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    add(1'b0, MEM_WORD,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    add(1'b1, MEM_BYTE,  32'h13, 32'h00000080, 32'h0,        1'b0);
    add(1'b0, MEM_BYTE,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
    add(1'b0, MEM_UBYTE, 32'h13, 32'h0,        32'h00000080, 1'b0);
    add(1'b0, MEM_WORD,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
    add(1'b0, MEM_HALF,  32'h11, 32'h0,        32'h0,        1'b1);
    add(1'b1, MEM_WORD,  32'h12, 32'h12345678, 32'h0,        1'b1);
    add(1'b0, MEM_WORD,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
    add(1'b1, MEM_WORD,  32'h00, 32'h11223344, 32'h0,        1'b0);
    add(1'b1, MEM_WORD,  32'h100, 32'hFFFFFFFF, 32'h0,       1'b1);
    add(1'b0, MEM_WORD,  32'h00, 32'h0,        32'h11223344, 1'b0);
    add(1'b0, MEM_HALF,  32'h12, 32'h0,        32'hFFFF80AD, 1'b0);
    add(1'b0, MEM_UHALF, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
    add(1'b0, MEM_HALF,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    add(1'b1, MEM_HALF,  32'h02, 32'hABCD7FFE, 32'h0,        1'b0);
    add(1'b0, MEM_HALF,  32'h02, 32'h0,        32'h00007FFE, 1'b0);
    add(1'b0, MEM_WORD,  32'h00, 32'h0,        32'h7FFE3344, 1'b0);
    add(1'b0, mem_dt_e'(3'd3), 32'h00, 32'h0,  32'h0,        1'b1);
    add(1'b0, MEM_BYTE,  32'h01, 32'h0,        32'h00000033, 1'b0);
    add(1'b0, MEM_UHALF, 32'h13, 32'h0,        32'h0,        1'b1);
    add(1'b1, MEM_WORD,  32'hFC, 32'hCAFEF00D, 32'h0,        1'b0);
    add(1'b0, MEM_WORD,  32'hFC, 32'h0,        32'hCAFEF00D, 1'b0);
    add(1'b1, MEM_WORD,  32'hFFFFFFFC, 32'h5A5A5A5A, 32'h0,  1'b1);
    add(1'b0, MEM_WORD,  32'hFC, 32'h0,        32'hCAFEF00D, 1'b0);

    // Reset state
    #1;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_rd",    rsp_rd,         32'd0);
    chk("rst rsp_err",   32'(rsp_err),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) run_vec(i);

    // Stalled response: slot held, ready low, then back-to-back accept on release
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, MEM_WORD, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall rsp_rd",    rsp_rd,         32'h80ADBEEF);
    drive(1'b0, MEM_WORD, 32'h00, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("stall%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d rsp_rd", k),    rsp_rd,         32'h80ADBEEF);
      chk($sformatf("stall%0d rsp_err", k),   32'(rsp_err),   32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b rsp_rd",    rsp_rd,         32'h7FFE3344);
    @(posedge clk);
    #1;
    chk("b2b drained", 32'(rsp_valid), 32'd0);

    // Reset with a pending response
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, MEM_WORD, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre-rst rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid-rst req_ready", 32'(req_ready), 32'd0);
    chk("mid-rst rsp_rd",    rsp_rd,         32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;

    vq.delete();
    add(1'b0, MEM_WORD, 32'h00, 32'h0, 32'h7FFE3344, 1'b0);
    add(1'b0, MEM_WORD, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    for (int i = 0; i < vq.size(); i++) run_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
